// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of the shared data memory.
// Round-robin on conflict, one checked memory access per grant, registered ack pulse.
module mem_port_arbiter #(
    parameter int MEM_BYTES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_ack,
    output logic [31:0]      i_rdata,
    output logic             i_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [2:0]       d_func3,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_ack,
    output logic [31:0]      d_rdata,
    output logic             d_err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             mem_write,
    output logic             mem_read,
    output logic [2:0]       mem_func3,
    input  logic [31:0]      mem_rdata,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic        port_d;
        logic        we;
        logic [2:0]  func3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } acc_t;

    state_t      state, state_nxt;
    acc_t        acc, acc_nxt;
    logic        last_d, last_d_nxt;
    logic        i_elig, d_elig, grant_d;
    logic        f3_bad, misal, oob, acc_ok, mem_go;
    logic [1:0]  size_m1;
    logic [32:0] acc_end;

    // A port is not re-granted in the cycle its own ack is showing.
    assign i_elig = i_req && !i_ack;
    assign d_elig = d_req && !d_ack;

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        last_d_nxt = last_d;
        grant_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_elig || d_elig) begin
                    grant_d    = d_elig && !(i_elig && last_d);
                    last_d_nxt = grant_d;
                    state_nxt  = BUSY;
                    if (grant_d)
                        acc_nxt = '{port_d: 1'b1, we: d_we, func3: d_func3,
                                    addr: d_addr, wdata: d_wdata};
                    else
                        acc_nxt = '{port_d: 1'b0, we: 1'b0, func3: 3'b010,
                                    addr: i_addr, wdata: 32'h0};
                end
            end
            BUSY: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Access check on the latched request; size_m1 is access bytes minus one.
    always_comb begin
        unique case (acc.func3[1:0])
            2'b00:   size_m1 = 2'd0;
            2'b01:   size_m1 = 2'd1;
            default: size_m1 = 2'd3;
        endcase
        f3_bad  = (acc.func3 == 3'b011) || (acc.func3 == 3'b110) || (acc.func3 == 3'b111) ||
                  (acc.func3[2] && acc.we);
        misal   = ((acc.func3[1:0] == 2'b10) && (acc.addr[1:0] != 2'b00)) ||
                  ((acc.func3[1:0] == 2'b01) && acc.addr[0]);
        acc_end = {1'b0, acc.addr} + {31'd0, size_m1};
        oob     = acc_end >= 33'(MEM_BYTES);
        acc_ok  = !(f3_bad || misal || oob);
    end

    // Memory is only driven in a BUSY cycle with a legal access and never under reset.
    assign mem_go    = (state == BUSY) && acc_ok && !rst;
    assign mem_addr  = mem_go ? acc.addr  : 32'h0;
    assign mem_wdata = mem_go ? acc.wdata : 32'h0;
    assign mem_func3 = mem_go ? acc.func3 : 3'b000;
    assign mem_read  = mem_go && !acc.we;
    assign mem_write = mem_go && acc.we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            last_d       <= 1'b1;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_err        <= 1'b0;
            d_err        <= 1'b0;
            i_rdata      <= 32'h0;
            d_rdata      <= 32'h0;
            conflict_cnt <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            last_d <= last_d_nxt;
            i_ack  <= (state == BUSY) && !acc.port_d;
            d_ack  <= (state == BUSY) && acc.port_d;
            if (state == BUSY) begin
                if (acc.port_d) begin
                    d_err   <= !acc_ok;
                    d_rdata <= (acc_ok && !acc.we) ? mem_rdata : 32'h0;
                end else begin
                    i_err   <= !acc_ok;
                    i_rdata <= acc_ok ? mem_rdata : 32'h0;
                end
            end
            if ((state == IDLE) && i_elig && d_elig && (conflict_cnt != '1))
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory model, per-port expected/observed
// queues, one task per scenario.
module tb_mem_port_arbiter;

    localparam int MEM_BYTES = 1024;
    localparam int CNT_W     = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_req;
    logic [31:0]      i_addr;
    logic             i_ack;
    logic [31:0]      i_rdata;
    logic             i_err;
    logic             d_req;
    logic             d_we;
    logic [2:0]       d_func3;
    logic [31:0]      d_addr;
    logic [31:0]      d_wdata;
    logic             d_ack;
    logic [31:0]      d_rdata;
    logic             d_err;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_write;
    logic             mem_read;
    logic [2:0]       mem_func3;
    logic [31:0]      mem_rdata;
    logic [CNT_W-1:0] conflict_cnt;

    mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_func3(d_func3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_func3(mem_func3), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: little-endian bytes, combinational read with load extension.
    logic [7:0] mem [MEM_BYTES];
    logic [9:0] ma;
    logic [7:0] b0, b1, b2, b3;
    assign ma = mem_addr[9:0];
    assign b0 = mem[ma];
    assign b1 = mem[ma + 10'd1];
    assign b2 = mem[ma + 10'd2];
    assign b3 = mem[ma + 10'd3];

    always_comb begin
        mem_rdata = {b3, b2, b1, b0};
        case (mem_func3)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b100:  mem_rdata = {24'h0, b0};
            3'b101:  mem_rdata = {16'h0, b1, b0};
            default: mem_rdata = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (mem_write) begin
            mem[ma] <= mem_wdata[7:0];
            if (mem_func3[1:0] != 2'b00) mem[ma + 10'd1] <= mem_wdata[15:8];
            if (mem_func3[1:0] == 2'b10) begin
                mem[ma + 10'd2] <= mem_wdata[23:16];
                mem[ma + 10'd3] <= mem_wdata[31:24];
            end
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        rchk;
    } exp_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } obs_t;

    exp_t i_exp[$];
    exp_t d_exp[$];
    obs_t i_obs[$];
    obs_t d_obs[$];
    logic order[$];
    obs_t mon_ob;

    int cyc     = 0;
    int wr_cnt  = 0;
    int acc_cnt = 0;
    int total   = 0;
    int bad     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation side of the scoreboard: completions and memory activity.
    always @(negedge clk) begin
        if (i_ack) begin
            mon_ob.rdata = i_rdata; mon_ob.err = i_err; mon_ob.cyc = cyc;
            i_obs.push_back(mon_ob);
            order.push_back(1'b0);
        end
        if (d_ack) begin
            mon_ob.rdata = d_rdata; mon_ob.err = d_err; mon_ob.cyc = cyc;
            d_obs.push_back(mon_ob);
            order.push_back(1'b1);
        end
        if (mem_write) wr_cnt = wr_cnt + 1;
        if (mem_read || mem_write) acc_cnt = acc_cnt + 1;
    end

    task automatic i_issue(input logic [31:0] addr, input logic [31:0] er, input logic ee,
                           output int c0);
        exp_t e;
        e.rdata = er; e.err = ee; e.rchk = 1'b1;
        i_exp.push_back(e);
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = addr; c0 = cyc;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (i_ack) break;
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic d_issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] er, input logic ee,
                           input logic rchk);
        exp_t e;
        e.rdata = er; e.err = ee; e.rchk = rchk;
        d_exp.push_back(e);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = we; d_func3 = f3; d_addr = addr; d_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (d_ack) break;
        end
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b1; i_addr = 32'h10;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, i_err, d_err, mem_read, mem_write} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000",
                     {i_ack, d_ack, i_err, d_err, mem_read, mem_write});
        end
        total++;
        if ({i_rdata, d_rdata} !== 64'h0) begin
            bad++; $display("FAIL reset_rdata got=%h_%h want=0", i_rdata, d_rdata);
        end
        total++;
        if ({mem_addr, mem_wdata, mem_func3} !== 67'h0) begin
            bad++; $display("FAIL reset_mem got=%h %h %h want=0", mem_addr, mem_wdata, mem_func3);
        end
        total++;
        if (conflict_cnt !== '0) begin
            bad++; $display("FAIL reset_cnt got=%0d want=0", conflict_cnt);
        end
        @(posedge clk); #1;
        i_req = 1'b0; rst = 1'b0;
    endtask

    task automatic test_fetch();
        exp_t e;
        obs_t o;
        int   c0, c1;
        d_issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        i_issue(32'h10, 32'hDEADBEEF, 1'b0, c0);
        i_issue(32'h400, 32'h0, 1'b1, c1);
        while (d_exp.size() > 0) begin
            e = d_exp.pop_front();
            total++;
            if (d_obs.size() == 0) begin
                bad++; $display("FAIL fetch_preload no d_ack");
            end else begin
                o = d_obs.pop_front();
                if (o.err !== e.err) begin
                    bad++; $display("FAIL fetch_preload err=%b want=%b", o.err, e.err);
                end
            end
        end
        for (int n = 0; n < 2; n++) begin
            e = i_exp.pop_front();
            total++;
            if (i_obs.size() == 0) begin
                bad++; $display("FAIL fetch_%0d no i_ack", n);
            end else begin
                o = i_obs.pop_front();
                if (o.err !== e.err || o.rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL fetch_%0d got err=%b rdata=%h want err=%b rdata=%h",
                             n, o.err, o.rdata, e.err, e.rdata);
                end
                if (n == 0) begin
                    total++;
                    if (o.cyc - c0 !== 2) begin
                        bad++; $display("FAIL fetch_latency got=%0d want=2", o.cyc - c0);
                    end
                end
            end
        end
    endtask

    task automatic test_load_ext();
        exp_t e;
        obs_t o;
        int   n;
        d_issue(1'b1, 3'b010, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0);
        d_issue(1'b0, 3'b000, 32'h23, 32'h0, 32'h00000012, 1'b0, 1'b1);
        d_issue(1'b0, 3'b001, 32'h22, 32'h0, 32'h00001234, 1'b0, 1'b1);
        d_issue(1'b0, 3'b000, 32'h21, 32'h0, 32'h00000056, 1'b0, 1'b1);
        d_issue(1'b1, 3'b010, 32'h24, 32'h80F0FF80, 32'h0, 1'b0, 1'b0);
        d_issue(1'b0, 3'b000, 32'h24, 32'h0, 32'hFFFFFF80, 1'b0, 1'b1);
        d_issue(1'b0, 3'b100, 32'h24, 32'h0, 32'h00000080, 1'b0, 1'b1);
        d_issue(1'b0, 3'b001, 32'h26, 32'h0, 32'hFFFF80F0, 1'b0, 1'b1);
        d_issue(1'b0, 3'b101, 32'h26, 32'h0, 32'h000080F0, 1'b0, 1'b1);
        n = 0;
        while (d_exp.size() > 0) begin
            e = d_exp.pop_front();
            total++;
            if (d_obs.size() == 0) begin
                bad++; $display("FAIL load_ext_%0d no d_ack", n);
            end else begin
                o = d_obs.pop_front();
                if (o.err !== e.err || (e.rchk && o.rdata !== e.rdata)) begin
                    bad++;
                    $display("FAIL load_ext_%0d got err=%b rdata=%h want err=%b rdata=%h",
                             n, o.err, o.rdata, e.err, e.rdata);
                end
            end
            n++;
        end
    endtask

    task automatic test_conflict();
        exp_t e;
        obs_t o;
        int   ci, cd;
        logic got_port;
        do_reset();
        order.delete();
        for (int r = 0; r < 4; r++) begin
            fork
                i_issue(32'h10, 32'hDEADBEEF, 1'b0, ci);
                d_issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, 1'b1);
            join
        end
        repeat (3) @(negedge clk);
        total++;
        if (conflict_cnt !== 16'd4) begin
            bad++; $display("FAIL conflict_cnt got=%0d want=4", conflict_cnt);
        end
        for (int g = 0; g < 8; g++) begin
            total++;
            if (order.size() == 0) begin
                bad++; $display("FAIL conflict_order_%0d no grant", g);
            end else begin
                got_port = order.pop_front();
                if (got_port !== g[0]) begin
                    bad++; $display("FAIL conflict_order_%0d got=%b want=%b", g, got_port, g[0]);
                end
            end
        end
        while (i_exp.size() > 0) begin
            e = i_exp.pop_front();
            total++;
            if (i_obs.size() == 0) begin
                bad++; $display("FAIL conflict_i no i_ack");
            end else begin
                o = i_obs.pop_front();
                if (o.err !== e.err || o.rdata !== e.rdata) begin
                    bad++; $display("FAIL conflict_i got %b %h want %b %h", o.err, o.rdata, e.err, e.rdata);
                end
            end
        end
        while (d_exp.size() > 0) begin
            e = d_exp.pop_front();
            total++;
            if (d_obs.size() == 0) begin
                bad++; $display("FAIL conflict_d no d_ack");
            end else begin
                o = d_obs.pop_front();
                if (o.err !== e.err || o.rdata !== e.rdata) begin
                    bad++; $display("FAIL conflict_d got %b %h want %b %h", o.err, o.rdata, e.err, e.rdata);
                end
            end
        end
        cd = 0;
    endtask

    task automatic test_errors();
        exp_t e;
        obs_t o;
        int   wc0, n;
        logic [31:0] w20;
        wc0 = wr_cnt;
        d_issue(1'b0, 3'b010, 32'h21,  32'h0,        32'h0, 1'b1, 1'b1);
        d_issue(1'b1, 3'b001, 32'h3FF, 32'hBEEF,     32'h0, 1'b1, 1'b1);
        d_issue(1'b0, 3'b011, 32'h20,  32'h0,        32'h0, 1'b1, 1'b1);
        d_issue(1'b0, 3'b010, 32'h400, 32'h0,        32'h0, 1'b1, 1'b1);
        d_issue(1'b1, 3'b000, 32'h400, 32'h55,       32'h0, 1'b1, 1'b1);
        d_issue(1'b1, 3'b100, 32'h20,  32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        d_issue(1'b1, 3'b110, 32'h20,  32'hFFFFFFFF, 32'h0, 1'b1, 1'b1);
        total++;
        if (wr_cnt !== wc0) begin
            bad++; $display("FAIL err_no_write got=%0d want=%0d", wr_cnt, wc0);
        end
        w20 = {mem[35], mem[34], mem[33], mem[32]};
        total++;
        if (w20 !== 32'h12345678) begin
            bad++; $display("FAIL err_mem_intact got=%h want=12345678", w20);
        end
        d_issue(1'b1, 3'b010, 32'h3FC, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0);
        d_issue(1'b0, 3'b100, 32'h3FF, 32'h0,        32'h000000CA, 1'b0, 1'b1);
        d_issue(1'b0, 3'b001, 32'h3FE, 32'h0,        32'hFFFFCAFE, 1'b0, 1'b1);
        d_issue(1'b0, 3'b010, 32'h3FC, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1);
        n = 0;
        while (d_exp.size() > 0) begin
            e = d_exp.pop_front();
            total++;
            if (d_obs.size() == 0) begin
                bad++; $display("FAIL errors_%0d no d_ack", n);
            end else begin
                o = d_obs.pop_front();
                if (o.err !== e.err || (e.rchk && o.rdata !== e.rdata)) begin
                    bad++;
                    $display("FAIL errors_%0d got err=%b rdata=%h want err=%b rdata=%h",
                             n, o.err, o.rdata, e.err, e.rdata);
                end
            end
            n++;
        end
    endtask

    task automatic test_reset_busy();
        exp_t e;
        obs_t o;
        int   wc0;
        logic [31:0] w40;
        d_issue(1'b1, 3'b010, 32'h40, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0);
        e = d_exp.pop_front();
        total++;
        if (d_obs.size() == 0) begin
            bad++; $display("FAIL rbusy_preload no d_ack");
        end else begin
            o = d_obs.pop_front();
            if (o.err !== e.err) begin
                bad++; $display("FAIL rbusy_preload err=%b want=%b", o.err, e.err);
            end
        end
        wc0 = wr_cnt;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_func3 = 3'b010; d_addr = 32'h40; d_wdata = 32'h11223344;
        @(posedge clk); #1;
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        total++;
        if ({mem_write, mem_read} !== 2'b00) begin
            bad++; $display("FAIL rbusy_mem_gate got=%b want=00", {mem_write, mem_read});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({i_ack, d_ack, i_err, d_err, mem_read, mem_write, i_rdata, d_rdata,
             mem_addr, mem_wdata, mem_func3, conflict_cnt} !== '0) begin
            bad++;
            $display("FAIL rbusy_outputs got ack=%b%b err=%b%b rd=%h/%h mem=%b%b %h %h cnt=%0d want all 0",
                     i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, mem_read, mem_write,
                     mem_addr, mem_wdata, conflict_cnt);
        end
        repeat (4) @(negedge clk);
        total++;
        if (d_obs.size() !== 0) begin
            bad++; $display("FAIL rbusy_no_ack got=%0d acks want=0", d_obs.size());
        end
        total++;
        if (wr_cnt !== wc0) begin
            bad++; $display("FAIL rbusy_no_write got=%0d want=%0d", wr_cnt, wc0);
        end
        w40 = {mem[67], mem[66], mem[65], mem[64]};
        total++;
        if (w40 !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL rbusy_mem got=%h want=a5a5a5a5", w40);
        end
        d_obs.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o1, o2;
        int   ac0, got;
        ac0 = acc_cnt;
        for (int n = 0; n < 2; n++) begin
            e.rdata = 32'h12345678; e.err = 1'b0; e.rchk = 1'b1;
            d_exp.push_back(e);
        end
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_func3 = 3'b010; d_addr = 32'h20; d_wdata = 32'h0;
        got = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (d_ack) begin
                got++;
                total++;
                if ({mem_read, mem_write} !== 2'b00) begin
                    bad++; $display("FAIL b2b_ack_cycle_access_%0d got=%b want=00", got, {mem_read, mem_write});
                end
                if (got == 2) break;
            end
        end
        @(posedge clk); #1;
        d_req = 1'b0;
        total++;
        if (d_obs.size() < 2) begin
            bad++; $display("FAIL b2b_acks got=%0d want=2", d_obs.size());
        end else begin
            o1 = d_obs.pop_front();
            o2 = d_obs.pop_front();
            e = d_exp.pop_front();
            if (o1.rdata !== e.rdata || o1.err !== e.err) begin
                bad++; $display("FAIL b2b_first got %b %h want %b %h", o1.err, o1.rdata, e.err, e.rdata);
            end
            e = d_exp.pop_front();
            total++;
            if (o2.rdata !== e.rdata || o2.err !== e.err) begin
                bad++; $display("FAIL b2b_second got %b %h want %b %h", o2.err, o2.rdata, e.err, e.rdata);
            end
            total++;
            if (o2.cyc - o1.cyc !== 3) begin
                bad++; $display("FAIL b2b_spacing got=%0d want=3", o2.cyc - o1.cyc);
            end
        end
        d_exp.delete();
        repeat (3) @(negedge clk);
        total++;
        if (acc_cnt - ac0 !== 2) begin
            bad++; $display("FAIL b2b_access_count got=%0d want=2", acc_cnt - ac0);
        end
        total++;
        if (d_rdata !== 32'h12345678 || d_ack !== 1'b0) begin
            bad++; $display("FAIL b2b_rdata_hold got=%h ack=%b want=12345678 ack=0", d_rdata, d_ack);
        end
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_func3 = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;
        test_reset();
        test_fetch();
        test_load_ext();
        test_conflict();
        test_errors();
        test_reset_busy();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
